intctl: RTL and testbench

- Interrupt scheduler for the 8085 core. Synchronises and latches TRAP, RST7.5, RST6.5, RST5.5 and INTR, and applies the SIM masks and the interrupt-enable (IE) flag.
- Arbitrates by fixed priority and presents one request plus a restart vector to the core control unit at instruction boundaries.
- Supplies the RIM read-back byte and drives the SOD serial output.

---
 rtl/intctl_if.sv | 25 ++
 rtl/intctl.sv | 182 ++++++++++++++++++
 tb/tb_intctl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/intctl_if.sv
// Core-side interface of the 8085 interrupt scheduler: SIM/EI/DI/boundary
// strobes from the control unit, request/vector/RIM data back to it.
interface intctl_if;
  logic        sim_wr;
  logic [7:0]  sim_dat;
  logic        ei_exec;
  logic        di_exec;
  logic        inst_end;
  logic        ack;
  logic        irq;
  logic [2:0]  isrc;
  logic [15:0] ivec;
  logic        inte;
  logic [7:0]  rim_dat;

  modport master (
    output sim_wr, sim_dat, ei_exec, di_exec, inst_end, ack,
    input  irq, isrc, ivec, inte, rim_dat
  );

  modport slave (
    input  sim_wr, sim_dat, ei_exec, di_exec, inst_end, ack,
    output irq, isrc, ivec, inte, rim_dat
  );
endinterface

// File: rtl/intctl.sv
// 8085 interrupt scheduler: pin synchronisers, TRAP/RST7.5 latches, SIM masks,
// IE flag, fixed-priority arbitration and request FSM, RIM byte and SOD.
module intctl_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_,
  input  logic rst_,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sh;

  always_ff @(posedge clk_ or posedge rst_)
    if (rst_) sh <= '0;
    else      sh <= {sh[STAGES-2:0], d};

  assign q = sh[STAGES-1];
endmodule

module intctl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_,
  input  logic        rst_,
  input  logic        trap,
  input  logic        rst75,
  input  logic        rst65,
  input  logic        rst55,
  input  logic        intr,
  input  logic        sid,
  output logic        sod,
  intctl_if.slave     cif
);
  localparam int NPIN = 6;
  typedef enum logic [1:0] {IDLE, REQ, ACK} st_t;

  logic [NPIN-1:0] pin_a, pin_s;
  logic trap_s, rst75_s, rst65_s, rst55_s, intr_s, sid_s;
  logic trap_d, rst75_d, trap_rise, r75_rise;
  logic trap_lat, r75_lat;
  logic [2:0] mask;
  logic inte_q, ei_dly;
  logic sv_t, sv_75, sv_65, sv_55, sv_i, cur_sv, ack_v;
  logic [7:0] sv8;
  logic [2:0] win;
  st_t st, st_n;
  logic irq_q, irq_n;
  logic [2:0] isrc_q, isrc_n;
  logic [15:0] ivec_q, ivec_n;

  assign pin_a = {sid, intr, rst55, rst65, rst75, trap};

  intctl_sync #(.STAGES(SYNC_STAGES)) u_sync [NPIN-1:0] (
    .clk_(clk_), .rst_(rst_), .d(pin_a), .q(pin_s)
  );

  assign {sid_s, intr_s, rst55_s, rst65_s, rst75_s, trap_s} = pin_s;
  assign trap_rise = trap_s & ~trap_d;
  assign r75_rise  = rst75_s & ~rst75_d;
  assign ack_v     = cif.ack && (st == REQ);

  // Edge requests count as serviceable in the edge cycle itself so every
  // source reaches irq SYNC_STAGES+1 cycles after the pin moves.
  assign sv_t  = (trap_lat | trap_rise) & trap_s;
  assign sv_75 = (r75_lat | r75_rise) & ~mask[2] & inte_q;
  assign sv_65 = rst65_s & ~mask[1] & inte_q;
  assign sv_55 = rst55_s & ~mask[0] & inte_q;
  assign sv_i  = intr_s & inte_q;
  assign sv8   = {2'b00, sv_i, sv_55, sv_65, sv_75, sv_t, 1'b0};
  assign cur_sv = sv8[isrc_q];

  always_comb begin
    win = 3'd0;
    if      (sv_t)  win = 3'd1;
    else if (sv_75) win = 3'd2;
    else if (sv_65) win = 3'd3;
    else if (sv_55) win = 3'd4;
    else if (sv_i)  win = 3'd5;
  end

  function automatic logic [15:0] vec_of(input logic [2:0] s);
    case (s)
      3'd1:    vec_of = 16'h0024;
      3'd2:    vec_of = 16'h003C;
      3'd3:    vec_of = 16'h0034;
      3'd4:    vec_of = 16'h002C;
      default: vec_of = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk_ or posedge rst_)
    if (rst_) begin
      trap_d   <= 1'b0;
      rst75_d  <= 1'b0;
      trap_lat <= 1'b0;
      r75_lat  <= 1'b0;
      mask     <= 3'b111;
      sod      <= 1'b0;
      inte_q   <= 1'b0;
      ei_dly   <= 1'b0;
    end else begin
      trap_d  <= trap_s;
      rst75_d <= rst75_s;
      if (trap_rise)                        trap_lat <= 1'b1;
      else if (ack_v && isrc_q == 3'd1)     trap_lat <= 1'b0;
      // A new RST7.5 edge beats a same-cycle SIM or ack clear.
      if (r75_rise)                         r75_lat <= 1'b1;
      else if ((cif.sim_wr && cif.sim_dat[4]) || (ack_v && isrc_q == 3'd2))
                                            r75_lat <= 1'b0;
      if (cif.sim_wr && cif.sim_dat[3]) mask <= cif.sim_dat[2:0];
      if (cif.sim_wr && cif.sim_dat[6]) sod  <= cif.sim_dat[7];
      if (cif.di_exec || ack_v) begin
        inte_q <= 1'b0;
        ei_dly <= 1'b0;
      end else if (cif.inst_end && ei_dly) begin
        inte_q <= 1'b1;
        ei_dly <= 1'b0;
      end else if (cif.ei_exec) begin
        ei_dly <= 1'b1;
      end
    end

  always_ff @(posedge clk_ or posedge rst_)
    if (rst_) begin
      st     <= IDLE;
      irq_q  <= 1'b0;
      isrc_q <= 3'd0;
      ivec_q <= 16'h0000;
    end else begin
      st     <= st_n;
      irq_q  <= irq_n;
      isrc_q <= isrc_n;
      ivec_q <= ivec_n;
    end

  always_comb begin
    st_n   = st;
    irq_n  = irq_q;
    isrc_n = isrc_q;
    ivec_n = ivec_q;
    case (st)
      IDLE: begin
        if (win != 3'd0) begin
          st_n   = REQ;
          irq_n  = 1'b1;
          isrc_n = win;
          ivec_n = vec_of(win);
        end else begin
          irq_n  = 1'b0;
          isrc_n = 3'd0;
          ivec_n = 16'h0000;
        end
      end
      REQ: begin
        if (cif.ack) begin
          st_n  = ACK;
          irq_n = 1'b0;
        end else if (win == 3'd0) begin
          st_n   = IDLE;
          irq_n  = 1'b0;
          isrc_n = 3'd0;
          ivec_n = 16'h0000;
        end else if (win < isrc_q || !cur_sv) begin
          // Preempt by a higher source, or fall back if ours went away.
          isrc_n = win;
          ivec_n = vec_of(win);
        end
      end
      ACK: begin
        st_n  = IDLE;
        irq_n = 1'b0;
      end
      default: st_n = IDLE;
    endcase
  end

  assign cif.irq     = irq_q;
  assign cif.isrc    = isrc_q;
  assign cif.ivec    = ivec_q;
  assign cif.inte    = inte_q;
  assign cif.rim_dat = {sid_s, r75_lat, rst65_s, rst55_s, inte_q, mask};
endmodule

// File: tb/tb_intctl.sv
// Directed bench for intctl: hand-computed expectations at fixed cycle
// offsets from each pin/strobe change (SYNC_STAGES = 2).
module tb_intctl;
  logic clk_ = 1'b0;
  logic rst_ = 1'b1;
  logic trap = 0, rst75 = 0, rst65 = 0, rst55 = 0, intr = 0, sid = 0;
  logic sod;
  int n_pass = 0;
  int n_chk  = 0;

  intctl_if cif ();

  intctl #(.SYNC_STAGES(2)) dut (
    .clk_(clk_), .rst_(rst_), .trap(trap), .rst75(rst75), .rst65(rst65),
    .rst55(rst55), .intr(intr), .sid(sid), .sod(sod), .cif(cif)
  );

  always #5 clk_ = ~clk_;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic sim(input logic [7:0] d);
    cif.sim_wr = 1'b1; cif.sim_dat = d;
    tick(1);
    cif.sim_wr = 1'b0; cif.sim_dat = 8'h00;
  endtask

  task automatic pulse_ack();
    cif.ack = 1'b1; tick(1); cif.ack = 1'b0;
  endtask

  task automatic ei_then_end();
    cif.ei_exec = 1'b1; tick(1); cif.ei_exec = 1'b0;
    cif.inst_end = 1'b1; tick(1); cif.inst_end = 1'b0;
  endtask

  initial begin
    cif.sim_wr = 0; cif.sim_dat = 0; cif.ei_exec = 0; cif.di_exec = 0;
    cif.inst_end = 0; cif.ack = 0;
    tick(2);
    chk("rst_irq", 16'(cif.irq), 16'h0);
    chk("rst_isrc", 16'(cif.isrc), 16'h0);
    chk("rst_ivec", cif.ivec, 16'h0000);
    chk("rst_inte", 16'(cif.inte), 16'h0);
    chk("rst_sod", 16'(sod), 16'h0);
    chk("rst_rim", 16'(cif.rim_dat), 16'h07);
    rst_ = 1'b0;
    tick(1);

    // RST5.5 via unmasked level after EI
    sim(8'h08);
    chk("mask_clr", 16'(cif.rim_dat), 16'h00);
    cif.ei_exec = 1'b1; tick(1); cif.ei_exec = 1'b0;
    cif.inst_end = 1'b1; tick(2); cif.inst_end = 1'b0;
    chk("ei_inte", 16'(cif.inte), 16'h1);
    rst55 = 1'b1;
    tick(2);
    chk("r55_early", 16'(cif.irq), 16'h0);
    tick(1);
    chk("r55_irq", 16'(cif.irq), 16'h1);
    chk("r55_isrc", 16'(cif.isrc), 16'h4);
    chk("r55_ivec", cif.ivec, 16'h002C);
    pulse_ack();
    chk("r55_ack_irq", 16'(cif.irq), 16'h0);
    chk("r55_ack_inte", 16'(cif.inte), 16'h0);
    chk("r55_ack_isrc", 16'(cif.isrc), 16'h4);
    tick(2);
    chk("r55_no_rereq", 16'(cif.irq), 16'h0);
    rst55 = 1'b0;
    tick(3);

    // TRAP with IE off: edge+level, drop, re-request
    trap = 1'b1;
    tick(3);
    chk("trap_irq", 16'(cif.irq), 16'h1);
    chk("trap_isrc", 16'(cif.isrc), 16'h1);
    chk("trap_ivec", cif.ivec, 16'h0024);
    trap = 1'b0;
    tick(2);
    chk("trap_hold", 16'(cif.irq), 16'h1);
    tick(1);
    chk("trap_drop_irq", 16'(cif.irq), 16'h0);
    chk("trap_drop_isrc", 16'(cif.isrc), 16'h0);
    trap = 1'b1;
    tick(3);
    chk("trap_rereq", 16'(cif.isrc), 16'h1);
    pulse_ack();
    chk("trap_ack_irq", 16'(cif.irq), 16'h0);
    tick(2);
    chk("trap_cleared", 16'(cif.irq), 16'h0);
    trap = 1'b0;
    tick(3);

    // RST7.5 latch, SIM clear, set-beats-clear
    sim(8'h0F);
    rst75 = 1'b1;
    tick(3);
    chk("r75_rim", 16'(cif.rim_dat), 16'h47);
    chk("r75_masked", 16'(cif.irq), 16'h0);
    rst75 = 1'b0;
    tick(3);
    sim(8'h18);
    chk("r75_simclr", 16'(cif.rim_dat), 16'h00);
    rst75 = 1'b1;
    tick(2);
    sim(8'h18);
    chk("r75_setwins", 16'(cif.rim_dat), 16'h40);
    rst75 = 1'b0;
    tick(3);
    sim(8'h18);
    chk("r75_clr2", 16'(cif.rim_dat), 16'h00);

    // RST6.5 + INTR, preempted by TRAP in REQ
    ei_then_end();
    chk("ie_on", 16'(cif.inte), 16'h1);
    rst65 = 1'b1; intr = 1'b1;
    tick(3);
    chk("r65_isrc", 16'(cif.isrc), 16'h3);
    chk("r65_ivec", cif.ivec, 16'h0034);
    trap = 1'b1;
    tick(2);
    chk("pre_hold", 16'(cif.isrc), 16'h3);
    tick(1);
    chk("pre_isrc", 16'(cif.isrc), 16'h1);
    chk("pre_ivec", cif.ivec, 16'h0024);
    chk("pre_irq", 16'(cif.irq), 16'h1);
    pulse_ack();
    chk("pre_ack_inte", 16'(cif.inte), 16'h0);
    chk("pre_ack_isrc", 16'(cif.isrc), 16'h1);
    tick(2);
    chk("pre_latch_clr", 16'(cif.irq), 16'h0);
    trap = 1'b0; rst65 = 1'b0; intr = 1'b0;
    tick(3);

    // EI/DI collision, then INTR
    cif.ei_exec = 1'b1; cif.di_exec = 1'b1; tick(1);
    cif.ei_exec = 1'b0; cif.di_exec = 1'b0;
    cif.inst_end = 1'b1; tick(1); cif.inst_end = 1'b0;
    chk("di_wins", 16'(cif.inte), 16'h0);
    ei_then_end();
    chk("ei_again", 16'(cif.inte), 16'h1);
    intr = 1'b1;
    tick(3);
    chk("intr_irq", 16'(cif.irq), 16'h1);
    chk("intr_isrc", 16'(cif.isrc), 16'h5);
    chk("intr_ivec", cif.ivec, 16'h0000);

    // SOD, SID read-back, async reset while in REQ
    sim(8'hC0);
    chk("sod_set", 16'(sod), 16'h1);
    sim(8'h80);
    chk("sod_hold", 16'(sod), 16'h1);
    sid = 1'b1;
    tick(1);
    chk("sid_early", 16'(cif.rim_dat[7]), 16'h0);
    tick(1);
    chk("sid_rim", 16'(cif.rim_dat), 16'h88);
    chk("req_before_rst", 16'(cif.irq), 16'h1);
    #2 rst_ = 1'b1;
    #1;
    chk("arst_irq", 16'(cif.irq), 16'h0);
    chk("arst_isrc", 16'(cif.isrc), 16'h0);
    chk("arst_rim", 16'(cif.rim_dat), 16'h07);
    chk("arst_sod", 16'(sod), 16'h0);
    intr = 1'b0; sid = 1'b0;
    tick(1);
    rst_ = 1'b0;
    tick(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
